// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for div.w/mod.w/div.wu/mod.wu
//   clk, rst (async, active-low); start/op/a/b/rd_in request; cancel flush
//   busy while computing; done pulse with registered result, rd_out, we_out
//   Define DIV_UNIT_FAST_SPECIAL_EN to let b==0, b==1 and signed overflow skip the iteration.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we_out
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [31:0] q, d, aa, bb, qf, rf, res;
  logic [32:0] r;
  logic [33:0] rs, diff;
  logic [4:0] cnt, rd;
  logic mod, sa, sb, bz, sgn, ge, accept;
  assign sgn    = ~op[1];
  assign aa     = (sgn && a[31]) ? -a : a;
  assign bb     = (sgn && b[31]) ? -b : b;
  assign accept = start && !cancel && (state == IDLE || state == DONE);
  assign busy   = state == CALC || state == FIX;
  assign done   = state == DONE;
  assign rs     = {r, q[31]};
  assign diff   = rs - {2'b0, d};
  assign ge     = !diff[33];
  // b==0 already yields an all-ones quotient from the iteration; leave it un-negated.
  assign qf     = (sa ^ sb && !bz) ? -q : q;
  assign rf     = sa ? -r[31:0] : r[31:0];
`ifdef DIV_UNIT_FAST_SPECIAL_EN
  logic sp;
  logic [31:0] araw;
  // q still holds |a| on the bypass cycle, so the raw dividend is recovered from its sign.
  assign araw = sa ? -q : q;
  assign res  = sp ? (mod ? (bz ? araw : 32'd0) : (bz ? 32'hFFFF_FFFF : araw)) : (mod ? rf : qf);
`else
  assign res  = mod ? rf : qf;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (cancel) state_n = IDLE;
    else
      case (state)
        IDLE, DONE: state_n = start ? CALC : IDLE;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
        CALC: state_n = sp ? DONE : (cnt == 5'd31 ? FIX : CALC);
`else
        CALC: state_n = cnt == 5'd31 ? FIX : CALC;
`endif
        default: state_n = DONE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      rd <= '0;
      mod <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      result <= '0;
      rd_out <= '0;
      we_out <= 1'b0;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
      sp <= 1'b0;
`endif
    end else begin
      if (accept) begin
        q <= aa;
        d <= bb;
        r <= '0;
        cnt <= '0;
        rd <= rd_in;
        mod <= op[0];
        sa <= sgn && a[31];
        sb <= sgn && b[31];
        bz <= b == 32'd0;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
        sp <= b == 32'd0 || b == 32'd1 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`endif
      end else if (state == CALC) begin
        q <= {q[30:0], ge};
        r <= ge ? diff[32:0] : rs[32:0];
        cnt <= cnt + 5'd1;
      end
      we_out <= state_n == DONE && rd != 5'd0;
      if (state_n == DONE) begin
        result <= res;
        rd_out <= rd;
      end
    end
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic clk = 0, rst = 0, start = 0, cancel = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic [4:0] rd_in = 0;
  logic busy, done, we_out;
  logic [31:0] result;
  logic [4:0] rd_out;
  int checks = 0, failures = 0;
  typedef struct packed {logic [1:0] o; logic [31:0] x, y, e;} vec_t;
  vec_t vt[18] = '{
    '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD},
    '{2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF},
    '{2'b11, 32'hFFFFFFF9, 32'd2, 32'd1},
    '{2'b10, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC},
    '{2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2},
    '{2'b01, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE},
    '{2'b10, 32'd1000, 32'd7, 32'd142},
    '{2'b11, 32'd1000, 32'd7, 32'd6},
    '{2'b00, 32'd100, 32'd0, 32'hFFFFFFFF},
    '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0},
    '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{2'b01, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9},
    '{2'b11, 32'd5, 32'd0, 32'd5},
    '{2'b10, 32'd5, 32'd0, 32'hFFFFFFFF},
    '{2'b00, 32'hFFFFFFF9, 32'd1, 32'hFFFFFFF9},
    '{2'b01, 32'd123, 32'd1, 32'd0},
    '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1},
    '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1}
  };

  div_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_in(rd_in),
    .cancel(cancel), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out));

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, y);
`ifdef DIV_UNIT_FAST_SPECIAL_EN
    if (y == 0 || y == 1 || (!o[1] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return 2;
`endif
    return 34;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, y, input logic [4:0] t);
    @(negedge clk);
    op = o; a = x; b = y; rd_in = t; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int from, output int lat, output int berr);
    lat = from; berr = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (done) break;
      if (!busy) berr++;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({busy, done, we_out} !== 3'b000 || result !== 0 || rd_out !== 0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b we=%b result=%h rd=%0d, want all zero", busy, done, we_out, result, rd_out);
    end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_arith;
    int lat, berr;
    for (int i = 0; i < 18; i++) begin
      issue(vt[i].o, vt[i].x, vt[i].y, 5'(i + 1));
      wait_done(0, lat, berr);
      checks++;
      if (lat !== exp_lat(vt[i].o, vt[i].x, vt[i].y) || berr !== 0 || busy !== 0) begin
        failures++;
        $display("FAIL timing[%0d]: done cycle=%0d busy gaps=%0d busy=%b, want %0d/0/0", i, lat, berr, busy, exp_lat(vt[i].o, vt[i].x, vt[i].y));
      end
      checks++;
      if (result !== vt[i].e || rd_out !== 5'(i + 1) || we_out !== 1) begin
        failures++;
        $display("FAIL result[%0d]: result=%h rd=%0d we=%b, want %h/%0d/1", i, result, rd_out, we_out, vt[i].e, i + 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 0 || we_out !== 0 || result !== vt[i].e) begin
        failures++;
        $display("FAIL hold[%0d]: done=%b we=%b result=%h, want 0/0/%h", i, done, we_out, result, vt[i].e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, berr;
    issue(2'b00, 32'd1000, 32'd10, 5'd3);
    repeat (10) @(negedge clk);
    op = 2'b10; a = 32'd7; b = 32'd1; rd_in = 5'd4; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(10, lat, berr);
    checks++;
    if (lat !== 34 || berr !== 0 || result !== 32'd100 || rd_out !== 5'd3) begin
      failures++;
      $display("FAIL ignore_start: cycle=%0d gaps=%0d result=%h rd=%0d, want 34/0/64/3", lat, berr, result, rd_out);
    end
    op = 2'b11; a = 32'd1000; b = 32'd7; rd_in = 5'd12; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(0, lat, berr);
    checks++;
    if (lat !== 34 || berr !== 0 || result !== 32'd6 || rd_out !== 5'd12 || we_out !== 1) begin
      failures++;
      $display("FAIL back_to_back: cycle=%0d gaps=%0d result=%h rd=%0d we=%b, want 34/0/6/12/1", lat, berr, result, rd_out, we_out);
    end
  endtask

  task automatic test_cancel;
    int lat, berr, nd;
    issue(2'b00, 32'd1000, 32'd10, 5'd3);
    repeat (20) @(negedge clk);
    cancel = 1;
    @(posedge clk); #1 cancel = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || result !== 32'd6) begin
      failures++;
      $display("FAIL cancel: busy=%b done=%b result=%h, want 0/0/6", busy, done, result);
    end
    nd = 0;
    repeat (40) begin @(negedge clk); if (done || busy) nd++; end
    checks++;
    if (nd !== 0 || result !== 32'd6) begin
      failures++;
      $display("FAIL cancel_quiet: activity=%0d result=%h, want 0/6", nd, result);
    end
    @(negedge clk);
    op = 2'b10; a = 32'd50; b = 32'd5; rd_in = 5'd7; start = 1; cancel = 1;
    @(posedge clk); #1 start = 0; cancel = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL cancel_priority: busy=%b, want 0", busy);
    end
    issue(2'b10, 32'd50, 32'd5, 5'd0);
    wait_done(0, lat, berr);
    checks++;
    if (lat !== 34 || done !== 1 || we_out !== 0 || result !== 32'd10 || rd_out !== 0) begin
      failures++;
      $display("FAIL rd_zero: cycle=%0d done=%b we=%b result=%h rd=%0d, want 34/1/0/a/0", lat, done, we_out, result, rd_out);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    issue(2'b00, 32'd1000, 32'd10, 5'd9);
    repeat (15) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({busy, done, we_out} !== 3'b000 || result !== 0 || rd_out !== 0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b we=%b result=%h rd=%0d, want all zero", busy, done, we_out, result, rd_out);
    end
    @(negedge clk); rst = 1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done || busy || we_out) nd++; end
    checks++;
    if (nd !== 0 || result !== 0) begin
      failures++;
      $display("FAIL reset_quiet: activity=%0d result=%h, want 0/0", nd, result);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_back_to_back;
    test_cancel;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
